// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU results with a buffered long-latency result FIFO
// Optional pending-write scoreboard output enabled by defining WB_PENDING_EN.
module wb_arbiter #(
    parameter int WORDSIZE   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            alu_valid,
    input  logic [4:0]                      alu_rd,
    input  logic [WORDSIZE-1:0]             alu_data,
    output logic                            alu_stall,
    input  logic                            lu_valid,
    output logic                            lu_ready,
    input  logic [4:0]                      lu_rd,
    input  logic [WORDSIZE-1:0]             lu_data,
    output logic                            regwrite,
    output logic [4:0]                      write1,
    output logic [WORDSIZE-1:0]             write_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overrun_err
`ifdef WB_PENDING_EN
    ,
    output logic [31:0]                     pending
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]          fifo_rd   [FIFO_DEPTH];
    logic [WORDSIZE-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [SW-1:0]       starve_cnt;

    logic fifo_empty;
    logic alu_ok;
    logic push;
    logic pop;
    logic sel_alu;
    logic drop;

    // Every flag here depends only on registered state plus this cycle's inputs;
    // lu_ready and alu_stall see registered state alone.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        lu_ready   = (fifo_count != CW'(FIFO_DEPTH));
        alu_stall  = (starve_cnt == SW'(STARVE_MAX));
        alu_ok     = alu_valid && (alu_rd != 5'd0);
        pop        = !fifo_empty && (alu_stall || !alu_ok);
        sel_alu    = alu_ok && !pop;
        drop       = alu_ok && pop;
        push       = lu_valid && lu_ready && (lu_rd != 5'd0);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= lu_rd;
            fifo_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            starve_cnt  <= '0;
            regwrite    <= 1'b0;
            write1      <= 5'd0;
            write_data  <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);

            if (pop || fifo_empty)
                starve_cnt <= '0;
            else if (sel_alu && !alu_stall)
                starve_cnt <= starve_cnt + 1'b1;

            regwrite <= pop || sel_alu;
            if (pop) begin
                write1     <= fifo_rd[rd_ptr];
                write_data <= fifo_data[rd_ptr];
            end else if (sel_alu) begin
                write1     <= alu_rd;
                write_data <= alu_data;
            end

            if (drop) overrun_err <= 1'b1;
        end
    end

`ifdef WB_PENDING_EN
    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PW-1:0] offs;
        pending = '0;
        offs    = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ({1'b0, offs} < fifo_count)
                pending[fifo_rd[PW'(i)]] = 1'b1;
        end
        pending[0] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic        CLK = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        regwrite;
    logic [4:0]  write1;
    logic [31:0] write_data;
    logic [2:0]  fifo_count;
    logic        overrun_err;
`ifdef WB_PENDING_EN
    logic [31:0] pending;
`endif

    wb_arbiter #(.WORDSIZE(32), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .regwrite(regwrite), .write1(write1), .write_data(write_data),
        .fifo_count(fifo_count), .overrun_err(overrun_err)
`ifdef WB_PENDING_EN
        , .pending(pending)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]  m_rd[$];
    logic [31:0] m_data[$];
    int          m_starve;
    bit          m_overrun;
    bit          m_regwrite;
    logic [4:0]  m_write1;
    logic [31:0] m_write_data;

    task automatic model_reset();
        m_rd.delete();
        m_data.delete();
        m_starve     = 0;
        m_overrun    = 0;
        m_regwrite   = 0;
        m_write1     = '0;
        m_write_data = '0;
    endtask

    // One clock of the arbiter's rules applied to the queue model.
    task automatic model_step(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                              input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
        bit stall, ready, busy, aok;
        stall = (m_starve == SMAX);
        ready = (m_rd.size() < DEPTH);
        busy  = (m_rd.size() != 0);
        aok   = av && (ard != 0);
        if (busy && (stall || !aok)) begin
            if (aok) m_overrun = 1;
            m_regwrite   = 1;
            m_write1     = m_rd.pop_front();
            m_write_data = m_data.pop_front();
            m_starve     = 0;
        end else if (aok) begin
            m_regwrite   = 1;
            m_write1     = ard;
            m_write_data = adata;
            m_starve     = busy ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end else begin
            m_regwrite = 0;
            m_starve   = 0;
        end
        if (lv && ready && lrd != 0) begin
            m_rd.push_back(lrd);
            m_data.push_back(ldata);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (m_rd[i]) p[m_rd[i]] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Drive one cycle of inputs just after an edge, advance the model, sample just after the next edge.
    task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] adata,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ldata);
        alu_valid = av; alu_rd = ard; alu_data = adata;
        lu_valid  = lv; lu_rd  = lrd; lu_data  = ldata;
        model_step(av, ard, adata, lv, lrd, ldata);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        model_reset();
        #1;
        n_tests++;
        if ({regwrite, write1, write_data, fifo_count, lu_ready, alu_stall, overrun_err} !== {1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rw=%b w1=%0d wd=%h cnt=%0d rdy=%b stall=%b ovr=%b, want 0/0/0/0/1/0/0",
                     regwrite, write1, write_data, fifo_count, lu_ready, alu_stall, overrun_err);
        end
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        n_tests++;
        if ({regwrite, write1, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL alu_write: got rw=%b w1=%0d wd=%h, want 1/5/deadbeef", regwrite, write1, write_data);
        end
        cycle(1, 5'd0, 32'h11111111, 0, 5'd0, 32'd0);
        n_tests++;
        if ({regwrite, write1, write_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL alu_x0: got rw=%b w1=%0d wd=%h, want 0/5/deadbeef", regwrite, write1, write_data);
        end
    endtask

    task automatic test_lu();
        cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h00001234);
        n_tests++;
        if ({regwrite, fifo_count} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL lu_push: got rw=%b cnt=%0d, want 0/1", regwrite, fifo_count);
        end
        idle(1);
        n_tests++;
        if ({regwrite, write1, write_data, fifo_count} !== {1'b1, 5'd7, 32'h00001234, 3'd0}) begin
            n_fail++;
            $display("FAIL lu_pop: got rw=%b w1=%0d wd=%h cnt=%0d, want 1/7/00001234/0", regwrite, write1, write_data, fifo_count);
        end
    endtask

    task automatic test_push_x0();
        cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'hCAFE0000);
        idle(1);
        n_tests++;
        if ({regwrite, fifo_count} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL push_x0: got rw=%b cnt=%0d, want 0/0", regwrite, fifo_count);
        end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 5'(10 + i), 32'(1000 + i), 1, 5'(i + 1), 32'(100 + i));
            n_tests++;
            if ({fifo_count, lu_ready, write1} !== {3'(i + 1), (i != 3), 5'(10 + i)}) begin
                n_fail++;
                $display("FAIL fill_%0d: got cnt=%0d rdy=%b w1=%0d, want %0d/%b/%0d",
                         i, fifo_count, lu_ready, write1, i + 1, (i != 3), 10 + i);
            end
        end
        // Three ALU wins so far over a non-empty FIFO; five more reach the limit.
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (alu_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL early_stall_%0d: got %b want 0", i, alu_stall);
            end
            cycle(1, 5'(20 + i), 32'(2000 + i), 0, 5'd0, 32'd0);
        end
        n_tests++;
        if ({alu_stall, fifo_count, write1} !== {1'b1, 3'd4, 5'd24}) begin
            n_fail++;
            $display("FAIL stall_on: got stall=%b cnt=%0d w1=%0d, want 1/4/24", alu_stall, fifo_count, write1);
        end
        cycle(1, 5'd9, 32'h99999999, 0, 5'd0, 32'd0);
        n_tests++;
        if ({regwrite, write1, write_data, overrun_err, alu_stall, fifo_count} !== {1'b1, 5'd1, 32'd100, 1'b1, 1'b0, 3'd3}) begin
            n_fail++;
            $display("FAIL overrun: got rw=%b w1=%0d wd=%0d ovr=%b stall=%b cnt=%0d, want 1/1/100/1/0/3",
                     regwrite, write1, write_data, overrun_err, alu_stall, fifo_count);
        end
        cycle(1, 5'd11, 32'h0B, 0, 5'd0, 32'd0);
        n_tests++;
        if ({write1, alu_stall} !== {5'd11, 1'b0}) begin
            n_fail++;
            $display("FAIL post_stall_alu: got w1=%0d stall=%b, want 11/0", write1, alu_stall);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_tests++;
            if ({regwrite, write1, write_data} !== {1'b1, 5'(i + 2), 32'(101 + i)}) begin
                n_fail++;
                $display("FAIL drain_%0d: got rw=%b w1=%0d wd=%0d, want 1/%0d/%0d", i, regwrite, write1, write_data, i + 2, 101 + i);
            end
        end
        idle(2);
        n_tests++;
        if ({overrun_err, fifo_count, regwrite} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL overrun_sticky: got ovr=%b cnt=%0d rw=%b, want 1/0/0", overrun_err, fifo_count, regwrite);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) cycle(1, 5'(12 + i), 32'(i), 1, 5'(20 + i), 32'(i));
        alu_valid = 0; lu_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({regwrite, fifo_count, lu_ready, overrun_err, alu_stall} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got rw=%b cnt=%0d rdy=%b ovr=%b stall=%b, want 0/0/1/0/0",
                     regwrite, fifo_count, lu_ready, overrun_err, alu_stall);
        end
        @(posedge CLK);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1);
            n_tests++;
            if ({regwrite, fifo_count, lu_ready} !== {1'b0, 3'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL stale_after_reset_%0d: got rw=%b cnt=%0d rdy=%b, want 0/0/1", i, regwrite, fifo_count, lu_ready);
            end
        end
    endtask

`ifdef WB_PENDING_EN
    task automatic test_pending();
        logic [31:0] want [4];
        want[0] = 32'h48; want[1] = 32'h48; want[2] = 32'h40; want[3] = 32'h0;
        cycle(1, 5'd20, 32'd0, 1, 5'd3, 32'd1);
        cycle(1, 5'd21, 32'd0, 1, 5'd3, 32'd2);
        cycle(1, 5'd22, 32'd0, 1, 5'd6, 32'd3);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (pending !== want[i]) begin
                n_fail++;
                $display("FAIL pending_%0d: got %h want %h", i, pending, want[i]);
            end
            idle(1);
        end
    endtask
`endif

    task automatic test_random();
        logic [43:0] got, exp;
        bit av, lv;
        logic [4:0] ard, lrd;
        for (int i = 0; i < 600; i++) begin
            av  = ($urandom_range(99) < ((i % 200) < 100 ? 92 : 45));
            lv  = ($urandom_range(99) < 55);
            ard = 5'($urandom_range(31));
            lrd = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
            cycle(av, ard, $urandom, lv, lrd, $urandom);
            got = {regwrite, write1, write_data, fifo_count, lu_ready, alu_stall, overrun_err};
            exp = {m_regwrite, m_regwrite ? m_write1 : write1, m_regwrite ? m_write_data : write_data,
                   3'(m_rd.size()), (m_rd.size() < DEPTH), (m_starve == SMAX), m_overrun};
            if (!m_regwrite) exp[42:6] = {m_write1, m_write_data};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: got rw=%b w1=%0d wd=%h cnt=%0d rdy=%b stall=%b ovr=%b, want %b/%0d/%h/%0d/%b/%b/%b",
                         i, regwrite, write1, write_data, fifo_count, lu_ready, alu_stall, overrun_err,
                         m_regwrite, m_write1, m_write_data, m_rd.size(), (m_rd.size() < DEPTH), (m_starve == SMAX), m_overrun);
            end
`ifdef WB_PENDING_EN
            n_tests++;
            if (pending !== model_pending()) begin
                n_fail++;
                $display("FAIL random_pending_%0d: got %h want %h", i, pending, model_pending());
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lu();
        test_push_x0();
        test_starve();
        test_reset_midop();
`ifdef WB_PENDING_EN
        test_pending();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
